// File: rtl/lsu_mem_handshake.sv
// lsu_mem_handshake
//   Load/store unit feeding the writeback mux load-data input. Converts each
//   load/store into a req/ack transaction on a multi-cycle data memory. It
//   also performs byte-lane steering, byte masks, sign/zero extension and
//   alignment checks, and stalls the core until the access completes.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), synchronous active-low reset
//   i_lsu_en, i_lsu_wren    load/store valid, 1=store
//   i_funct3                access width / signedness
//   i_addr, i_st_data       byte address, store data (rs2)
//   o_ld_data               registered, extended load result
//   o_stall                 hold PC and pipeline
//   o_done                  one-cycle pulse when an access completes
//   o_misaligned            misaligned or illegal access (combinational)
//   o_bus_err               one-cycle pulse on timeout (coincides with o_done)
//   o_mem_req/we/addr/wdata/bmask   memory request side
//   i_mem_ack, i_mem_rdata  memory completion side
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in flight; a legal access stalls and moves on
// ACCESS | request held on the memory bus, waiting for ack or timeout
// DONE   | access finished; o_done pulses, stall released

module lsu_mem_handshake #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_en,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [31:0] r_ld_data;
  logic        r_bus_err;

  logic        w_is_h;
  logic        w_is_w;
  logic        w_illegal;
  logic        w_misal;
  logic        w_go;
  logic        w_tc;
  logic [3:0]  w_bmask;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_ld_ext;

  // ---------------- access decode ----------------
  assign w_is_h = (i_funct3[1:0] == 2'b01);
  assign w_is_w = (i_funct3 == 3'b010);

  // Stores only know B/H/W; loads additionally allow BU/HU.
  assign w_illegal = i_lsu_wren
                   ? !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010)
                   :  (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);

  assign w_misal = (w_is_h & i_addr[0]) | (w_is_w & (i_addr[1:0] != 2'b00));

  assign o_misaligned = i_lsu_en & (w_misal | w_illegal);
  assign w_go         = i_lsu_en & ~o_misaligned;
  assign w_tc         = (r_cnt == TC_LAST);

  // ---------------- store lane steering ----------------
  always_comb begin
    w_bmask = 4'b1111;
    w_wdata = i_st_data;
    if (i_lsu_wren) begin
      case (i_funct3[1:0])
        2'b00: begin
          w_bmask = 4'b0001 << i_addr[1:0];
          w_wdata = {4{i_st_data[7:0]}};
        end
        2'b01: begin
          w_bmask = 4'b0011 << {i_addr[1], 1'b0};
          w_wdata = {2{i_st_data[15:0]}};
        end
        default: begin
          w_bmask = 4'b1111;
          w_wdata = i_st_data;
        end
      endcase
    end
  end

  // ---------------- load extraction ----------------
  assign w_lane = i_mem_rdata >> {i_addr[1:0], 3'b000};

  always_comb begin
    w_ld_ext = w_lane;
    case (i_funct3)
      3'b000:  w_ld_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_ld_ext = {24'h000000, w_lane[7:0]};
      3'b001:  w_ld_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_ld_ext = {16'h0000, w_lane[15:0]};
      default: w_ld_ext = w_lane;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_go) w_state_nxt = S_ACCESS;
      S_ACCESS: if (i_mem_ack || w_tc) w_state_nxt = S_DONE;
      // DONE never chains straight into a new access so the instruction
      // still presented by the stalled core is not replayed.
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_stall     = 1'b0;
    o_done      = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_bmask = 4'b0000;
    case (r_state)
      S_IDLE:   o_stall = w_go;
      S_ACCESS: begin
        o_stall     = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = i_lsu_wren;
        o_mem_bmask = w_bmask;
      end
      S_DONE:   o_done = 1'b1;
      default:  o_stall = 1'b0;
    endcase
  end

  assign o_mem_addr  = {i_addr[31:2], 2'b00};
  assign o_mem_wdata = w_wdata;

  // ---------------- timeout counter, load data, bus error ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= 16'd0;
      r_ld_data <= 32'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      if (r_state == S_ACCESS) begin
        if (i_mem_ack) begin
          r_cnt <= 16'd0;
          if (!i_lsu_wren) r_ld_data <= w_ld_ext;
        end else if (w_tc) begin
          // Ack has priority; only a silent final cycle counts as a timeout.
          r_cnt     <= 16'd0;
          r_bus_err <= 1'b1;
          if (!i_lsu_wren) r_ld_data <= 32'd0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else begin
        r_cnt <= 16'd0;
      end
    end
  end

  assign o_ld_data = r_ld_data;
  assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_lsu_mem_handshake.sv
module tb_lsu_mem_handshake;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_lsu_en = 1'b0;
  logic        i_lsu_wren = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_st_data = 32'd0;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;
  logic [31:0] o_ld_data;
  logic        o_stall, o_done, o_misaligned, o_bus_err;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;

  int checks = 0;
  int errors = 0;

  // observations from the last access driven by do_access
  int          obs_reqc;
  bit          obs_done;
  bit          obs_err;
  bit          obs_we;
  bit          obs_stall_ok;
  logic [3:0]  obs_bmask;
  logic [31:0] obs_wdata;
  logic [31:0] obs_addr;

  lsu_mem_handshake #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lsu_en(i_lsu_en), .i_lsu_wren(i_lsu_wren),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
    .o_ld_data(o_ld_data), .o_stall(o_stall), .o_done(o_done),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one access starting in the current (IDLE) cycle and runs it to
  // DONE. ack_at = index of the ACCESS cycle that acks (0 = never).
  // Returns in the DONE cycle with i_lsu_en already dropped.
  task automatic do_access(input bit wren, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] st, input logic [31:0] rdata, input int ack_at);
    i_lsu_en = 1'b1; i_lsu_wren = wren; i_funct3 = f3; i_addr = addr; i_st_data = st;
    i_mem_ack = 1'b0;
    #1;
    obs_stall_ok = o_stall;
    obs_reqc = 0; obs_done = 1'b0; obs_err = 1'b0;
    obs_we = 1'b0; obs_bmask = 4'h0; obs_wdata = 32'h0; obs_addr = 32'h0;
    for (int i = 0; i < 40 && !obs_done; i++) begin
      tick();
      i_mem_ack = 1'b0;
      if (o_mem_req) begin
        obs_reqc++;
        obs_bmask = o_mem_bmask; obs_wdata = o_mem_wdata;
        obs_we = o_mem_we; obs_addr = o_mem_addr;
        if (!o_stall) obs_stall_ok = 1'b0;
        if (obs_reqc == ack_at) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = rdata;
        end
      end else if (o_done) begin
        obs_done = 1'b1;
        obs_err = o_bus_err;
        if (o_stall) obs_stall_ok = 1'b0;
      end
    end
    i_lsu_en = 1'b0;
    i_mem_ack = 1'b0;
    i_mem_rdata = 32'h5A5A5A5A;
    checks++;
    if (!obs_done) begin
      errors++;
      $display("FAIL access_done_timeout: access addr=%h never reached DONE within budget", addr);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick(); tick();
    checks++; if (o_ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld_data: got %h want 00000000", o_ld_data); end
    checks++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0) begin errors++; $display("FAIL reset_req_we: got %b%b want 00", o_mem_req, o_mem_we); end
    checks++; if (o_done !== 1'b0 || o_bus_err !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL reset_done_err_stall: got %b%b%b want 000", o_done, o_bus_err, o_stall); end
    checks++; if (o_mem_bmask !== 4'h0) begin errors++; $display("FAIL reset_bmask: got %b want 0000", o_mem_bmask); end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 3);
    checks++; if (obs_reqc !== 3) begin errors++; $display("FAIL lw_req_cycles: got %0d want 3", obs_reqc); end
    checks++; if (obs_stall_ok !== 1'b1) begin errors++; $display("FAIL lw_stall_window: got %b want 1", obs_stall_ok); end
    checks++; if (o_ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", o_ld_data); end
    checks++; if (obs_bmask !== 4'b1111 || obs_we !== 1'b0 || obs_addr !== 32'h100) begin errors++; $display("FAIL lw_bus: got bmask=%b we=%b addr=%h want 1111 0 00000100", obs_bmask, obs_we, obs_addr); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL lw_no_err: got %b want 0", obs_err); end
    tick();
    checks++; if (o_done !== 1'b0 || o_stall !== 1'b0 || o_ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_after: got done=%b stall=%b ld=%h want 0 0 deadbeef", o_done, o_stall, o_ld_data); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] rds [4] = '{32'h80112233, 32'h80112233, 32'h80015566, 32'h80015566};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int k = 0; k < 4; k++) begin
      do_access(1'b0, f3s[k], adr[k], 32'h0, rds[k], 1);
      checks++; if (o_ld_data !== exp[k]) begin errors++; $display("FAIL load_ext[%0d]: got %h want %h", k, o_ld_data, exp[k]); end
      checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL load_word_addr[%0d]: got %h want 00000100", k, obs_addr); end
      tick();
    end
  endtask

  task automatic test_stores();
    do_access(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 2);
    checks++; if (obs_bmask !== 4'b0010 || obs_wdata !== 32'hABABABAB || obs_we !== 1'b1) begin errors++; $display("FAIL sb: got bmask=%b wdata=%h we=%b want 0010 abababab 1", obs_bmask, obs_wdata, obs_we); end
    checks++; if (o_ld_data !== 32'h00008001) begin errors++; $display("FAIL sb_ld_hold: got %h want 00008001", o_ld_data); end
    tick();
    do_access(1'b1, 3'b001, 32'h202, 32'hFFFF1234, 32'h0, 1);
    checks++; if (obs_bmask !== 4'b1100 || obs_wdata !== 32'h12341234) begin errors++; $display("FAIL sh: got bmask=%b wdata=%h want 1100 12341234", obs_bmask, obs_wdata); end
    tick();
    do_access(1'b1, 3'b010, 32'h204, 32'hCAFE0001, 32'h0, 1);
    checks++; if (obs_bmask !== 4'b1111 || obs_wdata !== 32'hCAFE0001 || obs_addr !== 32'h204) begin errors++; $display("FAIL sw: got bmask=%b wdata=%h addr=%h want 1111 cafe0001 00000204", obs_bmask, obs_wdata, obs_addr); end
    checks++; if (o_ld_data !== 32'h00008001) begin errors++; $display("FAIL store_ld_hold: got %h want 00008001", o_ld_data); end
    tick();
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
    logic [31:0] adr [4] = '{32'h102, 32'h100, 32'h201, 32'h200};
    bit          wrs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          reqs;
    for (int k = 0; k < 4; k++) begin
      i_lsu_en = 1'b1; i_lsu_wren = wrs[k]; i_funct3 = f3s[k]; i_addr = adr[k];
      #1;
      checks++; if (o_misaligned !== 1'b1 || o_stall !== 1'b0) begin errors++; $display("FAIL misal_flag[%0d]: got mis=%b stall=%b want 1 0", k, o_misaligned, o_stall); end
      reqs = 0;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (o_mem_req || o_done) reqs++;
      end
      checks++; if (reqs !== 0) begin errors++; $display("FAIL misal_no_req[%0d]: got %0d active cycles want 0", k, reqs); end
      i_lsu_en = 1'b0;
      #1;
      checks++; if (o_misaligned !== 1'b0) begin errors++; $display("FAIL misal_gated[%0d]: got %b want 0", k, o_misaligned); end
    end
    checks++; if (o_ld_data !== 32'h00008001) begin errors++; $display("FAIL misal_ld_hold: got %h want 00008001", o_ld_data); end
    tick();
  endtask

  task automatic test_timeout();
    do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0);
    checks++; if (obs_reqc !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", obs_reqc); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b want 1", obs_err); end
    checks++; if (o_ld_data !== 32'h0) begin errors++; $display("FAIL to_ld_zero: got %h want 00000000", o_ld_data); end
    tick();
    checks++; if (o_bus_err !== 1'b0 || o_done !== 1'b0 || o_mem_req !== 1'b0) begin errors++; $display("FAIL to_idle: got err=%b done=%b req=%b want 000", o_bus_err, o_done, o_mem_req); end
    // ack in the very cycle the timeout would fire
    do_access(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 4);
    checks++; if (obs_err !== 1'b0 || obs_reqc !== 4) begin errors++; $display("FAIL ack_vs_to: got err=%b reqc=%0d want 0 4", obs_err, obs_reqc); end
    checks++; if (o_ld_data !== 32'hCAFEF00D) begin errors++; $display("FAIL ack_vs_to_data: got %h want cafef00d", o_ld_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    i_lsu_en = 1'b1; i_lsu_wren = 1'b0; i_funct3 = 3'b010; i_addr = 32'h400;
    tick(); tick();
    checks++; if (o_mem_req !== 1'b1) begin errors++; $display("FAIL rmid_in_access: got req=%b want 1", o_mem_req); end
    i_rst_n = 1'b0; i_lsu_en = 1'b0;
    tick();
    checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_ld_data !== 32'h0) begin errors++; $display("FAIL rmid_reset: got req=%b stall=%b ld=%h want 0 0 00000000", o_mem_req, o_stall, o_ld_data); end
    i_rst_n = 1'b1;
    tick();
    do_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 1);
    checks++; if (o_ld_data !== 32'h12345678 || obs_reqc !== 1) begin errors++; $display("FAIL rmid_after: got ld=%h reqc=%0d want 12345678 1", o_ld_data, obs_reqc); end
    tick();
  endtask

  task automatic test_back_to_back();
    int reqs = 0;
    int dones = 0;
    logic [31:0] got [2] = '{32'h0, 32'h0};
    i_lsu_en = 1'b1; i_lsu_wren = 1'b0; i_funct3 = 3'b010; i_addr = 32'h500;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o_mem_req) begin
        reqs++;
        i_mem_ack = 1'b1;
        i_mem_rdata = (reqs == 1) ? 32'h11111111 : 32'h22222222;
      end else begin
        i_mem_ack = 1'b0;
      end
      if (o_done) begin
        if (dones < 2) got[dones] = o_ld_data;
        dones++;
      end
    end
    i_lsu_en = 1'b0; i_mem_ack = 1'b0;
    checks++; if (reqs !== 2 || dones !== 2) begin errors++; $display("FAIL b2b_counts: got req=%0d done=%0d want 2 2", reqs, dones); end
    checks++; if (got[0] !== 32'h11111111 || got[1] !== 32'h22222222) begin errors++; $display("FAIL b2b_data: got %h %h want 11111111 22222222", got[0], got[1]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
